// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction memory front end.
// Serves word fetches from a combinational-read instruction memory and
// streams loader words into it one byte per cycle (little-endian).
// Loader requests win over fetches; requests are only looked at in IDLE.
module imem_ctrl #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W-1:0] r_addr_imem,
  input  logic [31:0]       r_data_imem,
  output logic              w_en_imem,
  output logic [ADDR_W-1:0] w_addr_imem,
  output logic [7:0]        w_data_imem
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LD0   = 3'd2;
  localparam logic [2:0] S_LD1   = 3'd3;
  localparam logic [2:0] S_LD2   = 3'd4;
  localparam logic [2:0] S_LD3   = 3'd5;

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [ADDR_W-1:0] ld_base;
  logic [31:0]       ld_word;
  logic              ld_active;
  logic [1:0]        ld_offset;

  // Next-state selection: loader first, then fetch, only from IDLE.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (load_req)
          next_state = S_LD0;
        else if (fetch_req)
          next_state = S_FETCH;
      end
      S_FETCH: next_state = S_IDLE;
      S_LD0:   next_state = S_LD1;
      S_LD1:   next_state = S_LD2;
      S_LD2:   next_state = S_LD3;
      S_LD3:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register plus request latches and the registered result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      r_addr_imem <= '0;
      ld_base     <= '0;
      ld_word     <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_data  <= '0;
      load_done   <= 1'b0;
    end else begin
      state       <= next_state;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      load_done   <= 1'b0;
      if (state == S_IDLE) begin
        if (load_req) begin
          ld_base <= load_addr;
          ld_word <= load_data;
        end else if (fetch_req) begin
          r_addr_imem <= fetch_addr;
        end
      end
      if (state == S_FETCH) begin
        fetch_data  <= r_data_imem;
        fetch_valid <= 1'b1;
        fetch_err   <= (r_addr_imem[1:0] != 2'b00);
      end
      if (state == S_LD3)
        load_done <= 1'b1;
    end
  end

  // Byte lane selection for the four load states; outputs idle at zero.
  always_comb begin
    ld_active = 1'b0;
    ld_offset = 2'd0;
    case (state)
      S_LD0: begin ld_active = 1'b1; ld_offset = 2'd0; end
      S_LD1: begin ld_active = 1'b1; ld_offset = 2'd1; end
      S_LD2: begin ld_active = 1'b1; ld_offset = 2'd2; end
      S_LD3: begin ld_active = 1'b1; ld_offset = 2'd3; end
      default: begin ld_active = 1'b0; ld_offset = 2'd0; end
    endcase
  end

  // Write port drive; the address add wraps naturally at ADDR_W bits.
  always_comb begin
    w_en_imem   = ld_active;
    load_busy   = ld_active;
    w_addr_imem = '0;
    w_data_imem = '0;
    if (ld_active) begin
      w_addr_imem = ld_base + ADDR_W'(ld_offset);
      case (ld_offset)
        2'd0:    w_data_imem = ld_word[7:0];
        2'd1:    w_data_imem = ld_word[15:8];
        2'd2:    w_data_imem = ld_word[23:16];
        default: w_data_imem = ld_word[31:24];
      endcase
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: self-checking bench for imem_ctrl with a byte-array
// memory attached and a word-level reference model of its contents.
module tb_imem_ctrl;

  localparam int AW        = 7;
  localparam int MEM_BYTES = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_valid;
  logic [31:0]   fetch_data;
  logic          fetch_err;
  logic          load_req = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic          load_busy;
  logic          load_done;
  logic [AW-1:0] r_addr_imem;
  logic [31:0]   r_data_imem;
  logic          w_en_imem;
  logic [AW-1:0] w_addr_imem;
  logic [7:0]    w_data_imem;

  logic [7:0]    mem [MEM_BYTES];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_data = '0;
  logic [AW-1:0] rd1, rd2, rd3;

  logic [7:0]    ref_mem [MEM_BYTES];
  int            checks = 0;
  int            failures = 0;

  imem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_busy(load_busy), .load_done(load_done),
    .r_addr_imem(r_addr_imem), .r_data_imem(r_data_imem),
    .w_en_imem(w_en_imem), .w_addr_imem(w_addr_imem), .w_data_imem(w_data_imem)
  );

  always #5 clk = ~clk;

  // Instruction memory: byte writes from the DUT, preload path from the bench.
  always @(posedge clk) begin
    if (w_en_imem)
      mem[w_addr_imem] <= w_data_imem;
    else if (pre_en)
      mem[pre_addr] <= pre_data;
  end

  assign rd1 = r_addr_imem + AW'(1);
  assign rd2 = r_addr_imem + AW'(2);
  assign rd3 = r_addr_imem + AW'(3);
  assign r_data_imem = {mem[rd3], mem[rd2], mem[rd1], mem[r_addr_imem]};

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[(a + 3) % MEM_BYTES], ref_mem[(a + 2) % MEM_BYTES],
            ref_mem[(a + 1) % MEM_BYTES], ref_mem[a % MEM_BYTES]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Fetch from IDLE (or from the cycle right after load_done): data in cycle 2.
  task automatic applyFetch(input logic [AW-1:0] addr);
    bit seen = 0;
    logic [31:0] exp_word;
    exp_word   = ref_word(int'(addr));
    fetch_addr = addr;
    fetch_req  = 1'b1;
    for (int cyc = 1; cyc <= 8 && !seen; cyc++) begin
      stepCycle();
      checkOutput("fetch_no_load_done", {31'd0, load_done}, 32'd0);
      if (fetch_valid) begin
        seen = 1;
        fetch_req = 1'b0;
        checkOutput("fetch_latency", cyc, 32'd2);
        checkOutput("fetch_data", fetch_data, exp_word);
        checkOutput("fetch_err", {31'd0, fetch_err}, {31'd0, addr[1:0] != 2'b00});
        checkOutput("fetch_r_addr", {25'd0, r_addr_imem}, {25'd0, addr});
      end
    end
    if (!seen) checkOutput("fetch_timeout", 32'd0, 32'd1);
    stepCycle();
    checkOutput("fetch_valid_pulse", {31'd0, fetch_valid}, 32'd0);
    checkOutput("fetch_data_hold", fetch_data, exp_word);
  endtask

  // Loader word: four byte writes starting the cycle after acceptance, then load_done.
  task automatic applyLoad(input logic [AW-1:0] addr, input logic [31:0] data);
    bit done = 0;
    int nwr = 0;
    load_addr = addr;
    load_data = data;
    load_req  = 1'b1;
    for (int cyc = 1; cyc <= 12 && !done; cyc++) begin
      stepCycle();
      checkOutput("load_no_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      if (cyc == 1) checkOutput("load_start", {31'd0, w_en_imem}, 32'd1);
      if (w_en_imem) begin
        checkOutput("load_w_addr", {25'd0, w_addr_imem}, (int'(addr) + nwr) % MEM_BYTES);
        checkOutput("load_w_data", {24'd0, w_data_imem}, {24'd0, data[8*(nwr%4) +: 8]});
        checkOutput("load_busy_on", {31'd0, load_busy}, 32'd1);
        nwr++;
      end else if (load_done) begin
        done = 1;
        load_req = 1'b0;
        checkOutput("load_write_count", nwr, 32'd4);
        checkOutput("load_busy_off", {31'd0, load_busy}, 32'd0);
      end
    end
    if (!done) checkOutput("load_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 4; i++)
      ref_mem[(int'(addr) + i) % MEM_BYTES] = data[8*i +: 8];
  endtask

  initial begin
    logic [31:0] rnd;
    logic [AW-1:0] ra;

    // Reset and preload the memory with random bytes (plus a known word at 0x08).
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
    ref_mem[8] = 8'h93; ref_mem[9] = 8'h00; ref_mem[10] = 8'h50; ref_mem[11] = 8'h00;
    #1;
    checkOutput("reset_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    checkOutput("reset_fetch_data", fetch_data, 32'd0);
    checkOutput("reset_load_busy", {31'd0, load_busy}, 32'd0);
    checkOutput("reset_w_en", {31'd0, w_en_imem}, 32'd0);
    checkOutput("reset_r_addr", {25'd0, r_addr_imem}, 32'd0);
    pre_en = 1'b1;
    for (int i = 0; i < MEM_BYTES; i++) begin
      pre_addr = AW'(i);
      pre_data = ref_mem[i];
      stepCycle();
    end
    pre_en = 1'b0;
    checkOutput("reset_hold_load_done", {31'd0, load_done}, 32'd0);
    checkOutput("reset_hold_fetch_err", {31'd0, fetch_err}, 32'd0);
    rst = 1'b0;
    stepCycle();

    // Directed: known word, load, wrap, misaligned.
    applyFetch(7'h08);
    checkOutput("known_word_0x08", fetch_data, 32'h00500093);
    applyLoad(7'h10, 32'hDEADBEEF);
    applyFetch(7'h10);
    checkOutput("load_readback_0x10", fetch_data, 32'hDEADBEEF);
    applyLoad(7'h7E, 32'h11223344);
    applyFetch(7'h7E);
    checkOutput("wrap_readback_0x7E", fetch_data, 32'h11223344);
    applyFetch(7'h05);

    // Contention: both requests rise together; load first, fetch after.
    fetch_addr = 7'h10;
    fetch_req  = 1'b1;
    applyLoad(7'h10, 32'hCAFEF00D);
    applyFetch(7'h10);

    // Reset during LD2: bytes 0 and 1 stay, no load_done.
    load_addr = 7'h20;
    load_data = 32'hA1B2C3D4;
    load_req  = 1'b1;
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("mid_load_ld2_addr", {25'd0, w_addr_imem}, 32'h22);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_load_rst_w_en", {31'd0, w_en_imem}, 32'd0);
    checkOutput("mid_load_rst_busy", {31'd0, load_busy}, 32'd0);
    checkOutput("mid_load_rst_w_data", {24'd0, w_data_imem}, 32'd0);
    load_req = 1'b0;
    stepCycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("mid_load_no_done", {31'd0, load_done}, 32'd0);
      checkOutput("mid_load_no_w_en", {31'd0, w_en_imem}, 32'd0);
    end
    ref_mem[8'h20] = 8'hD4;
    ref_mem[8'h21] = 8'hC3;
    applyFetch(7'h20);

    // Reset during FETCH: no fetch_valid; held request accepted on first clean edge.
    fetch_addr = 7'h08;
    fetch_req  = 1'b1;
    stepCycle();
    #2 rst = 1'b1;
    #1;
    checkOutput("fetch_rst_valid", {31'd0, fetch_valid}, 32'd0);
    checkOutput("fetch_rst_data", fetch_data, 32'd0);
    checkOutput("fetch_rst_r_addr", {25'd0, r_addr_imem}, 32'd0);
    stepCycle();
    checkOutput("fetch_rst_valid_held", {31'd0, fetch_valid}, 32'd0);
    rst = 1'b0;
    applyFetch(7'h08);

    // Randomized mix of loads and fetches against the reference model.
    for (int n = 0; n < 40; n++) begin
      rnd = $urandom;
      ra  = AW'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 2) == 0)
        applyLoad(ra, rnd);
      else
        applyFetch(ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
